instruction_fetch_unit: RTL and testbench

Fetch-stage block that consumes the current `pc` from the program counter and retrieves the instruction word from instruction memory over a request/response handshake with variable latency. The instruction is latched into an instruction register for decode. The block reports completion to the control FSM, which then issues the `pc_control` update. It also flags misaligned fetch addresses, supports flushing an in-flight fetch, and counts retired fetches.

---
 rtl/instruction_fetch_unit.sv | 109 ++++++++++
 tb/tb_instruction_fetch_unit.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: drives a request/response read of instruction memory
// at the current pc and latches the returned word into the IR.
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   pc, fetch_start      fetch request from the control FSM
//   flush                abandon an in-flight fetch
//   mem_req, mem_addr    registered read request to memory
//   mem_ready            request accepted this cycle
//   mem_rvalid/rdata     read response
//   ir, ir_pc            instruction register and its address
//   fetch_done           one-cycle pulse when ir/ir_pc are new
//   busy, misaligned     status flags
//   fetch_count          completed fetches, wraps
module instruction_fetch_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic        fetch_start,
  input  logic        flush,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic [31:0] ir,
  output logic [31:0] ir_pc,
  output logic        fetch_done,
  output logic        busy,
  output logic        misaligned,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DRAIN
  } state_t;

  state_t state;
  state_t state_d;
  logic   accept;
  logic   aligned;
  logic   complete;

  // Flush blocks a start in IDLE; a flushed read is never retired.
  assign accept   = (state == IDLE) && fetch_start && !flush;
  assign aligned  = (pc[1:0] == 2'b00);
  assign complete = (state == WAIT) && mem_rvalid && !flush;

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: begin
        if (accept && aligned)
          state_d = REQ;
      end
      REQ: begin
        // A handshake in the flush cycle leaves a response
        // outstanding, which DRAIN absorbs.
        if (flush)
          state_d = mem_ready ? DRAIN : IDLE;
        else if (mem_ready)
          state_d = WAIT;
      end
      WAIT: begin
        if (mem_rvalid)
          state_d = IDLE;
        else if (flush)
          state_d = DRAIN;
      end
      DRAIN: begin
        if (mem_rvalid)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      mem_req     <= 1'b0;
      mem_addr    <= 32'h0;
      ir          <= 32'h0000_0013;
      ir_pc       <= 32'h0;
      fetch_done  <= 1'b0;
      busy        <= 1'b0;
      misaligned  <= 1'b0;
      fetch_count <= 32'h0;
    end else begin
      state      <= state_d;
      mem_req    <= (state_d == REQ);
      busy       <= (state_d != IDLE);
      fetch_done <= complete;
      if (accept) begin
        misaligned <= !aligned;
        if (aligned)
          mem_addr <= pc;
      end
      if (complete) begin
        ir          <= mem_rdata;
        ir_pc       <= mem_addr;
        fetch_count <= fetch_count + 32'h1;
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Testbench for instruction_fetch_unit: directed and randomized
// fetch transactions checked against a transaction-level model.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc = 32'h0;
  logic        fetch_start = 1'b0;
  logic        flush = 1'b0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic [31:0] ir;
  logic [31:0] ir_pc;
  logic        fetch_done;
  logic        busy;
  logic        misaligned;
  logic [31:0] fetch_count;

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  logic [31:0] m_ir  = 32'h0000_0013;
  logic [31:0] m_pc  = 32'h0;
  logic [31:0] m_cnt = 32'h0;

  instruction_fetch_unit dut (
    .clk(clk),
    .reset(reset),
    .pc(pc),
    .fetch_start(fetch_start),
    .flush(flush),
    .mem_req(mem_req),
    .mem_addr(mem_addr),
    .mem_ready(mem_ready),
    .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata),
    .ir(ir),
    .ir_pc(ir_pc),
    .fetch_done(fetch_done),
    .busy(busy),
    .misaligned(misaligned),
    .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_req"}, mem_req, 0);
    chk({tag, "_done"}, fetch_done, 0);
    chk({tag, "_ir"}, ir, m_ir);
    chk({tag, "_irpc"}, ir_pc, m_pc);
    chk({tag, "_cnt"}, fetch_count, m_cnt);
  endtask

  // One fetch starting this cycle. rw: cycles of mem_ready low,
  // vw: cycles between handshake+1 and rvalid. fm: 0 none,
  // 1 flush at REQ cycle fk, 2 flush at WAIT cycle fk.
  task automatic fetch(input logic [31:0] a, input logic [31:0] d,
                       input int rw, input int vw,
                       input int fm, input int fk);
    bit flushed;
    bit outstanding;
    int rem;
    flushed = 0;
    outstanding = 0;
    fetch_start = 1'b1;
    pc = a;
    step();
    fetch_start = 1'b0;
    if (a[1:0] != 2'b00) begin
      chk("mis_flag", misaligned, 1);
      chk_idle("mis");
      return;
    end
    chk("mis_clear", misaligned, 0);
    for (int i = 0; i <= rw; i++) begin
      chk("req", mem_req, 1);
      chk("req_addr", mem_addr, a);
      chk("req_busy", busy, 1);
      chk("req_done", fetch_done, 0);
      mem_ready = (i == rw);
      fetch_start = 1'($urandom_range(0, 1));
      pc = $urandom;
      if (fm == 1 && i == fk) begin
        flush = 1'b1;
        flushed = 1;
        outstanding = mem_ready;
      end
      step();
      flush = 1'b0;
      mem_ready = 1'b0;
      fetch_start = 1'b0;
      if (flushed) break;
    end
    if (!flushed) begin
      for (int i = 0; i <= vw; i++) begin
        chk("wait_req", mem_req, 0);
        chk("wait_busy", busy, 1);
        chk("wait_done", fetch_done, 0);
        mem_rvalid = (i == vw);
        mem_rdata = mem_rvalid ? d : $urandom;
        fetch_start = 1'($urandom_range(0, 1));
        if (fm == 2 && i == fk) begin
          flush = 1'b1;
          flushed = 1;
          outstanding = !mem_rvalid;
        end
        step();
        flush = 1'b0;
        mem_rvalid = 1'b0;
        fetch_start = 1'b0;
        if (flushed) break;
      end
    end
    if (!flushed) begin
      m_ir = d;
      m_pc = a;
      m_cnt = m_cnt + 32'h1;
      chk("done", fetch_done, 1);
      chk("done_ir", ir, m_ir);
      chk("done_irpc", ir_pc, m_pc);
      chk("done_cnt", fetch_count, m_cnt);
      chk("done_busy", busy, 0);
      return;
    end
    if (outstanding) begin
      rem = (fm == 1) ? vw : vw - fk - 1;
      for (int i = 0; i <= rem; i++) begin
        chk("drain_busy", busy, 1);
        chk("drain_req", mem_req, 0);
        chk("drain_done", fetch_done, 0);
        mem_rvalid = (i == rem);
        mem_rdata = d;
        flush = 1'($urandom_range(0, 1));
        fetch_start = 1'($urandom_range(0, 1));
        step();
        mem_rvalid = 1'b0;
        flush = 1'b0;
        fetch_start = 1'b0;
      end
    end
    chk_idle("flushed");
  endtask

  initial begin
    int rw;
    int vw;
    int fm;
    int fk;
    logic [31:0] a;

    step();
    step();
    reset = 1'b0;
    chk_idle("rst");
    chk("rst_mis", misaligned, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_nop", ir, 32'h0000_0013);

    fetch(32'h10, 32'h0050_0093, 0, 0, 0, 0);
    fetch(32'h20, 32'h0010_0113, 3, 1, 0, 0);
    fetch(32'h6, 32'h0, 0, 0, 0, 0);
    fetch(32'h24, 32'h0020_0193, 1, 0, 0, 0);
    fetch(32'h30, 32'hDEAD_BEEF, 0, 2, 2, 0);
    fetch(32'h34, 32'h1111_1111, 2, 0, 1, 1);
    fetch(32'h38, 32'h2222_2222, 2, 1, 1, 2);

    // Start with flush in IDLE is not accepted; stray rvalid ignored.
    fetch_start = 1'b1;
    flush = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata = 32'hBAD0_BAD0;
    pc = 32'h40;
    step();
    fetch_start = 1'b0;
    flush = 1'b0;
    mem_rvalid = 1'b0;
    chk_idle("idle_flush");

    force dut.fetch_count = 32'hFFFF_FFFF;
    #1;
    release dut.fetch_count;
    m_cnt = 32'hFFFF_FFFF;
    chk("preload", fetch_count, 32'hFFFF_FFFF);
    fetch(32'h44, 32'h0000_0513, 0, 0, 0, 0);
    chk("wrap", fetch_count, 0);

    repeat (80) begin
      rw = $urandom_range(0, 3);
      vw = $urandom_range(0, 3);
      fm = ($urandom_range(0, 3) == 0) ? 1 : 0;
      if ($urandom_range(0, 3) == 0) fm = 2;
      fk = (fm == 1) ? $urandom_range(0, rw) : $urandom_range(0, vw);
      a = $urandom;
      if ($urandom_range(0, 4) != 0) a[1:0] = 2'b00;
      fetch(a, $urandom, rw, vw, fm, fk);
      if ($urandom_range(0, 2) == 0) begin
        mem_rvalid = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
        flush = 1'($urandom_range(0, 1));
        step();
        mem_rvalid = 1'b0;
        flush = 1'b0;
        chk_idle("gap");
      end
    end

    fetch_start = 1'b1;
    pc = 32'h80;
    step();
    fetch_start = 1'b0;
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    chk("pre_rst_busy", busy, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    m_ir = 32'h0000_0013;
    m_pc = 32'h0;
    m_cnt = 32'h0;
    chk_idle("mid_rst");
    mem_rvalid = 1'b1;
    mem_rdata = 32'hCAFE_F00D;
    step();
    mem_rvalid = 1'b0;
    chk_idle("stale");
    fetch(32'h84, 32'h0030_0213, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
